// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================
// vga_text_pkg : shared constants and FSM state type for the
//                80x30 text console writer.  Rev 1.0
// ============================================================
package vga_text_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;
  localparam int DEF_WPR  = DEF_COLS / 4;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUT    = 3'd1,
    SCR_RD = 3'd2,
    SCR_WR = 3'd3,
    FILL   = 3'd4
  } state_t;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == CC_BS) || (b == CC_LF) || (b == CC_FF) || (b == CC_CR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_word_sequencer.sv
`default_nettype none
// ============================================================
// vram_word_sequencer : word index counter for bulk VRAM ops
//                       (row-copy phase, then fill phase). Rev 1.0
// ============================================================
module vram_word_sequencer
  import vga_text_pkg::*;
#(
  parameter int WPR    = DEF_WPR,
  parameter int NWORDS = DEF_WPR * DEF_ROWS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       start_copy,
  input  logic       adv,
  output logic [9:0] idx,
  output logic       copy_last,
  output logic       done
);

  localparam logic [9:0] COPY_END = 10'(NWORDS - WPR - 1);
  localparam logic [9:0] FILL_END = 10'(NWORDS - 1);

  logic copy;
  logic fill_last;

  assign copy_last = copy && (idx == COPY_END);
  assign fill_last = !copy && (idx == FILL_END);
  assign done      = adv && fill_last;

  // The copy phase hands over to the fill phase at the same index stream,
  // so a scroll fills exactly the last row without reloading the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      copy <= 1'b0;
    end else if (start) begin
      idx  <= '0;
      copy <= start_copy;
    end else if (adv && !fill_last) begin
      idx <= idx + 10'd1;
      if (copy_last) copy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_text_console.sv
`default_nettype none
// ============================================================
// vga_text_console : byte-stream text writer with cursor,
//                    control codes, clear and scroll.  Rev 1.0
// ============================================================
module vga_text_console
  import vga_text_pkg::*;
#(
  parameter int         COLS      = DEF_COLS,
  parameter int         ROWS      = DEF_ROWS,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [9:0]  vram_addr,
  output logic        vram_we,
  output logic [3:0]  vram_be,
  output logic [31:0] vram_wdata,
  input  logic [31:0] vram_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam int         WPR    = COLS / 4;
  localparam int         NWORDS = WPR * ROWS;
  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);
  localparam logic [9:0] WPR_W  = 10'(WPR);

  state_t      state;
  logic [7:0]  char_q;
  logic [9:0]  put_addr;
  logic [9:0]  seq_idx;
  logic        seq_adv;
  logic        seq_copy_last;
  logic        seq_done;

  assign put_addr = 10'(cursor_y) * WPR_W + {5'd0, cursor_x[6:2]};
  assign seq_adv  = (state == SCR_WR) || (state == FILL);
  assign busy     = (state == SCR_RD) || (state == SCR_WR) || (state == FILL);
  assign ch_ready = rst_n && (state == IDLE);

  // Reloaded on every PUT cycle; only matters when PUT exits to a bulk op.
  vram_word_sequencer #(
    .WPR    (WPR),
    .NWORDS (NWORDS)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (state == PUT),
    .start_copy (char_q != CC_FF),
    .adv        (seq_adv),
    .idx        (seq_idx),
    .copy_last  (seq_copy_last),
    .done       (seq_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      char_q   <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ch_valid) begin
            char_q <= ch_data;
            state  <= PUT;
          end
        end
        PUT: begin
          state <= IDLE;
          if (char_q == CC_CR) begin
            cursor_x <= '0;
          end else if (char_q == CC_BS) begin
            if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
          end else if (char_q == CC_FF) begin
            cursor_x <= '0;
            cursor_y <= '0;
            state    <= FILL;
          end else if ((char_q == CC_LF) || (cursor_x == X_LAST)) begin
            cursor_x <= '0;
            if (cursor_y != Y_LAST) cursor_y <= cursor_y + 5'd1;
            else                    state    <= SCR_RD;
          end else begin
            cursor_x <= cursor_x + 7'd1;
          end
        end
        SCR_RD:  state <= SCR_WR;
        SCR_WR:  state <= seq_copy_last ? FILL : SCR_RD;
        FILL:    if (seq_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // VRAM port is a decode of registered state so the copy path can forward
  // read data straight into the write one cycle after the read address.
  always_comb begin
    vram_addr  = '0;
    vram_we    = 1'b0;
    vram_be    = '0;
    vram_wdata = '0;
    case (state)
      PUT: begin
        if (!is_ctrl(char_q)) begin
          vram_addr  = put_addr;
          vram_we    = 1'b1;
          vram_be    = 4'b0001 << cursor_x[1:0];
          vram_wdata = {4{char_q}};
        end
      end
      SCR_RD: begin
        vram_addr = seq_idx + WPR_W;
      end
      SCR_WR: begin
        vram_addr  = seq_idx;
        vram_we    = 1'b1;
        vram_be    = 4'hF;
        vram_wdata = vram_rdata;
      end
      FILL: begin
        vram_addr  = seq_idx;
        vram_we    = 1'b1;
        vram_be    = 4'hF;
        vram_wdata = {4{FILL_CHAR}};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_text_console.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// tb_vga_text_console : scoreboard bench for the text console
//                       writer with a behavioural VRAM.  Rev 1.0
// ============================================================
module tb_vga_text_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic [9:0]  vram_addr;
  logic        vram_we;
  logic [3:0]  vram_be;
  logic [31:0] vram_wdata;
  logic [31:0] vram_rdata = 32'h0;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;
  logic        preload = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  vga_text_console dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_be    (vram_be),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural VRAM: byte-masked write, registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int j = 0; j < 1024; j++) mem[j] <= 32'hA500_0000 | 32'(j);
    end else if (vram_we) begin
      for (int k = 0; k < 4; k++)
        if (vram_be[k]) mem[vram_addr][8*k +: 8] <= vram_wdata[8*k +: 8];
    end
    vram_rdata <= mem[vram_addr];
  end

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vram_we) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d be=%b data=%h, none expected", vram_addr, vram_be, vram_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (vram_addr !== e.a || vram_be !== e.be || vram_wdata !== e.d) begin
            n_fail++;
            $display("FAIL vram_write: got addr=%0d be=%b data=%h, expected addr=%0d be=%b data=%h",
                     vram_addr, vram_be, vram_wdata, e.a, e.be, e.d);
          end
        end
      end else begin
        n_checks++;
        if (vram_be !== 4'b0000) begin
          n_fail++;
          $display("FAIL idle_be: got be=%b, expected 0000", vram_be);
        end
      end
    end
  end

  function automatic void expect_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_t w;
    w.a = a; w.be = be; w.d = d;
    exp_q.push_back(w);
    for (int k = 0; k < 4; k++)
      if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
  endfunction

  function automatic void expect_scroll();
    for (int j = 0; j < 580; j++) expect_write(10'(j), 4'hF, ref_mem[j + 20]);
    for (int j = 580; j < 600; j++) expect_write(10'(j), 4'hF, 32'h2020_2020);
  endfunction

  // Waits (bounded) for ready, hands over one byte, returns in the PUT cycle.
  task automatic send(input logic [7:0] b);
    int t = 0;
    while (ch_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (ch_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: ch_ready=%b after %0d cycles, expected 1", ch_ready, t);
    end
    ch_valid = 1'b1;
    ch_data  = b;
    @(posedge clk);
    #1 ch_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ch_valid = 1'b0; preload = 1'b1;
    for (int j = 0; j < 1024; j++) ref_mem[j] = 32'hA500_0000 | 32'(j);
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ch_ready); end
    n_checks++;
    if ({vram_we, vram_be, vram_addr, vram_wdata} !== 47'd0) begin
      n_fail++;
      $display("FAIL reset_vram: got we=%b be=%b addr=%0d data=%h expected all 0", vram_we, vram_be, vram_addr, vram_wdata);
    end
    n_checks++;
    if (busy !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_cursor: got busy=%b x=%0d y=%0d expected 0 0 0", busy, cursor_x, cursor_y);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready: got %b expected 1", ch_ready); end
  endtask

  task automatic test_single_char();
    expect_write(10'd0, 4'b0001, 32'h4141_4141);
    send(8'h41);
    n_checks++;
    if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL put_ready_low: got %b expected 0", ch_ready); end
    @(negedge clk);
    n_checks++;
    if (ch_ready !== 1'b1 || cursor_x !== 7'd1 || cursor_y !== 5'd0) begin
      n_fail++;
      $display("FAIL single_char: got ready=%b x=%0d y=%0d expected 1 1 0", ch_ready, cursor_x, cursor_y);
    end
  endtask

  task automatic test_five_chars();
    logic [7:0] msg [5];
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    send(8'h0D);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd0) begin n_fail++; $display("FAIL cr: got x=%0d expected 0", cursor_x); end
    for (int k = 0; k < 5; k++) begin
      expect_write(10'(k / 4), 4'b0001 << (k % 4), {4{msg[k]}});
      send(msg[k]);
    end
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd5 || cursor_y !== 5'd0) begin
      n_fail++; $display("FAIL five_chars: got x=%0d y=%0d expected 5 0", cursor_x, cursor_y);
    end
  endtask

  task automatic test_inverse_and_bs();
    send(8'h08);
    send(8'h08);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd3) begin n_fail++; $display("FAIL backspace: got x=%0d expected 3", cursor_x); end
    expect_write(10'd0, 4'b1000, 32'hC1C1_C1C1);
    send(8'hC1);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd4) begin n_fail++; $display("FAIL inverse_adv: got x=%0d expected 4", cursor_x); end
    send(8'h0D);
    send(8'h08);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      n_fail++; $display("FAIL bs_at_zero: got x=%0d y=%0d expected 0 0", cursor_x, cursor_y);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pending_writes: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_scroll();
    int cyc = 0;
    for (int k = 0; k < 29; k++) send(8'h0A);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd29) begin
      n_fail++; $display("FAIL linefeeds: got x=%0d y=%0d expected 0 29", cursor_x, cursor_y);
    end
    for (int k = 0; k < 79; k++) begin
      logic [7:0] b;
      b = 8'h30 + 8'(k % 40);
      expect_write(10'(580 + k / 4), 4'b0001 << (k % 4), {4{b}});
      send(b);
    end
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd79) begin n_fail++; $display("FAIL row_fill: got x=%0d expected 79", cursor_x); end
    expect_write(10'd599, 4'b1000, 32'h5A5A_5A5A);
    expect_scroll();
    send(8'h5A);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd29) begin
      n_fail++; $display("FAIL scroll_cursor_early: got x=%0d y=%0d expected 0 29", cursor_x, cursor_y);
    end
    while (busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc !== 1180) begin n_fail++; $display("FAIL scroll_busy_cycles: got %0d expected 1180", cyc); end
    n_checks++;
    if (ch_ready !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 5'd29) begin
      n_fail++; $display("FAIL scroll_end: got ready=%b x=%0d y=%0d expected 1 0 29", ch_ready, cursor_x, cursor_y);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scroll_pending: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_clear();
    int cyc = 0;
    for (int j = 0; j < 600; j++) expect_write(10'(j), 4'hF, 32'h2020_2020);
    send(8'h0C);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      n_fail++; $display("FAIL clear_cursor_early: got x=%0d y=%0d expected 0 0", cursor_x, cursor_y);
    end
    while (busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc !== 600) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 600", cyc); end
    n_checks++;
    if (ch_ready !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      n_fail++; $display("FAIL clear_end: got ready=%b x=%0d y=%0d expected 1 0 0", ch_ready, cursor_x, cursor_y);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL clear_pending: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_scroll();
    for (int k = 0; k < 29; k++) send(8'h0A);
    expect_scroll();
    send(8'h0A);
    ch_valid = 1'b1;
    ch_data  = 8'h51;
    repeat (100) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || ch_ready !== 1'b0 || cursor_y !== 5'd29) begin
      n_fail++; $display("FAIL mid_scroll: got busy=%b ready=%b y=%0d expected 1 0 29", busy, ch_ready, cursor_y);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ch_ready, busy, vram_we, vram_be, vram_addr, vram_wdata, cursor_x, cursor_y} !== 61'd0) begin
      n_fail++;
      $display("FAIL async_reset: got ready=%b busy=%b we=%b be=%b addr=%0d data=%h x=%0d y=%0d expected all 0",
               ch_ready, busy, vram_we, vram_be, vram_addr, vram_wdata, cursor_x, cursor_y);
    end
    exp_q.delete();
    expect_write(10'd0, 4'b0001, 32'h5151_5151);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_abort: got %b expected 1", ch_ready); end
    @(posedge clk);
    #1 ch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin
      n_fail++; $display("FAIL post_abort_cursor: got x=%0d y=%0d expected 1 0", cursor_x, cursor_y);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL post_abort_pending: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_five_chars();
    test_inverse_and_bs();
    test_scroll();
    test_clear();
    test_reset_mid_scroll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
